mac_rx_buffer: RTL and testbench

MAC_RX_BUFFER -- requirements
Module: mac_rx_buffer

---
 rtl/mac_params.sv | 25 ++
 rtl/mac_rx_buffer.sv | 128 ++++++++++++
 tb/tb_mac_rx_buffer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_params.sv
// Shared constants, write-FSM states and entry layout for the MAC receive buffer.
package mac_params;

  localparam int unsigned N_CHANNELS       = 4;
  localparam int unsigned W_BYTE           = 8;
  localparam int unsigned W_DATA           = N_CHANNELS * W_BYTE;
  localparam int unsigned N_MAC_RX_BUF     = 16;
  localparam int unsigned W_MAC_RX_BUF_CNT = 4;
  localparam int unsigned W_MAC_RX_BUF     = W_DATA + N_CHANNELS + 1;
  localparam int unsigned W_PTR            = W_MAC_RX_BUF_CNT + 1;
  localparam int unsigned W_DROP_CNT       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic                  last;
    logic [N_CHANNELS-1:0] keep;
    logic [W_DATA-1:0]     data;
  } rx_entry_t;

endpackage

// File: rtl/mac_rx_buffer.sv
// Frame-commit receive FIFO: words become readable only once their frame ends with good FCS;
// bad or overflowing frames are rolled back and counted.
module mac_rx_buffer
  import mac_params::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clk_en,
  input  logic                  i_clr,
  input  logic                  i_wen,
  input  logic [N_CHANNELS-1:0] i_wkeep,
  input  logic [W_DATA-1:0]     i_wdata,
  input  logic                  i_weof,
  input  logic                  i_wgood,
  input  logic                  i_ren,
  output logic [N_CHANNELS-1:0] o_rkeep,
  output logic [W_DATA-1:0]     o_rdata,
  output logic                  o_rlast,
  output logic                  o_empty,
  output logic                  o_overflow,
  output logic [W_DROP_CNT-1:0] o_drop_cnt
);

  wr_state_t             state_q, state_d;
  logic [W_PTR-1:0]      wptr_q, wptr_d;
  logic [W_PTR-1:0]      rptr_q, rptr_d;
  logic [W_PTR-1:0]      commit_q, commit_d;
  logic [W_DROP_CNT-1:0] drop_cnt_q;
  logic                  ovf_q, ovf_d;
  logic                  we, drop_inc;
  logic                  full, empty;
  logic [W_PTR-1:0]      fill;
  rx_entry_t             mem_q [N_MAC_RX_BUF];
  rx_entry_t             wentry, head;

  // Occupancy counts uncommitted words too, so a frame cannot overrun the reader.
  assign fill   = wptr_q - rptr_q;
  assign full   = (fill == W_PTR'(N_MAC_RX_BUF));
  assign empty  = (rptr_q == commit_q);
  assign wentry = '{last: i_weof, keep: i_wkeep, data: i_wdata};
  assign head   = mem_q[rptr_q[W_MAC_RX_BUF_CNT-1:0]];

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    commit_d = commit_q;
    we       = 1'b0;
    ovf_d    = 1'b0;
    drop_inc = 1'b0;

    case (state_q)
      IDLE, RECV: begin
        if (i_wen) begin
          if (full) begin
            wptr_d   = commit_q;
            ovf_d    = 1'b1;
            drop_inc = 1'b1;
            state_d  = i_weof ? IDLE : DROP;
          end else begin
            we     = 1'b1;
            wptr_d = wptr_q + W_PTR'(1);
            if (i_weof) begin
              state_d = IDLE;
              if (i_wgood) begin
                commit_d = wptr_q + W_PTR'(1);
              end else begin
                wptr_d   = commit_q;
                drop_inc = 1'b1;
              end
            end else begin
              state_d = RECV;
            end
          end
        end
      end
      DROP: begin
        if (i_wen && i_weof) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_ren && !empty) rptr_d = rptr_q + W_PTR'(1);

    // Flush wins over any concurrent read or write.
    if (i_clr) begin
      state_d  = IDLE;
      wptr_d   = '0;
      rptr_d   = '0;
      commit_d = '0;
      we       = 1'b0;
      ovf_d    = 1'b0;
      drop_inc = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      commit_q   <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < int'(N_MAC_RX_BUF); i++) mem_q[i] <= '0;
    end else begin
      ovf_q <= 1'b0;
      if (i_clk_en) begin
        state_q  <= state_d;
        wptr_q   <= wptr_d;
        rptr_q   <= rptr_d;
        commit_q <= commit_d;
        ovf_q    <= ovf_d;
        if (we) mem_q[wptr_q[W_MAC_RX_BUF_CNT-1:0]] <= wentry;
        if (drop_inc && (drop_cnt_q != {W_DROP_CNT{1'b1}}))
          drop_cnt_q <= drop_cnt_q + W_DROP_CNT'(1);
      end
    end
  end

  assign o_rkeep    = head.keep;
  assign o_rdata    = head.data;
  assign o_rlast    = head.last;
  assign o_empty    = empty;
  assign o_overflow = ovf_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_mac_rx_buffer.sv
// Self-checking bench for mac_rx_buffer: a cycle vector table plus scoreboarded frame sequences.
module tb_mac_rx_buffer;
  import mac_params::*;

  logic                  i_clk = 1'b0;
  logic                  i_reset, i_clk_en, i_clr, i_wen, i_weof, i_wgood, i_ren;
  logic [N_CHANNELS-1:0] i_wkeep;
  logic [W_DATA-1:0]     i_wdata;
  logic [N_CHANNELS-1:0] o_rkeep;
  logic [W_DATA-1:0]     o_rdata;
  logic                  o_rlast, o_empty, o_overflow;
  logic [15:0]           o_drop_cnt;

  mac_rx_buffer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en), .i_clr(i_clr),
    .i_wen(i_wen), .i_wkeep(i_wkeep), .i_wdata(i_wdata), .i_weof(i_weof),
    .i_wgood(i_wgood), .i_ren(i_ren), .o_rkeep(o_rkeep), .o_rdata(o_rdata),
    .o_rlast(o_rlast), .o_empty(o_empty), .o_overflow(o_overflow),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        wen, eof, good, ren, clr;
    logic [3:0]  keep;
    logic [31:0] data;
    logic        e_empty, e_ovf;
    logic [15:0] e_drop;
    logic        e_last;
    logic [3:0]  e_keep;
    logic [31:0] e_data;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vt[12];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_drop;

  function automatic vec_t mk(logic wen, logic eof, logic good, logic ren, logic clr,
                              logic [3:0] keep, logic [31:0] data, logic e_empty,
                              logic [15:0] e_drop, logic e_last, logic [3:0] e_keep,
                              logic [31:0] e_data);
    vec_t v;
    v.wen = wen; v.eof = eof; v.good = good; v.ren = ren; v.clr = clr;
    v.keep = keep; v.data = data; v.e_empty = e_empty; v.e_ovf = 1'b0;
    v.e_drop = e_drop; v.e_last = e_last; v.e_keep = e_keep; v.e_data = e_data;
    return v;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic put_word(input logic [31:0] d, input logic [3:0] k, input logic eof,
                          input logic good);
    i_wen = 1'b1; i_wdata = d; i_wkeep = k; i_weof = eof; i_wgood = good;
    tick();
    i_wen = 1'b0; i_weof = 1'b0; i_wgood = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic good, input logic [31:0] base,
                            input logic [3:0] last_keep);
    for (int i = 0; i < n; i++) begin
      logic       last;
      logic [3:0] k;
      last = (i == n - 1);
      k    = last ? last_keep : 4'hF;
      if (good) sb_q.push_back({last, k, base + 32'(i)});
      put_word(base + 32'(i), k, last, good);
    end
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_sb: got empty scoreboard expected an entry", nm);
      return;
    end
    e = sb_q.pop_front();
    chk({nm, "_empty"}, 32'(o_empty), 32'd0);
    chk({nm, "_data"}, o_rdata, e.data);
    chk({nm, "_keep"}, 32'(o_rkeep), 32'(e.keep));
    chk({nm, "_last"}, 32'(o_rlast), 32'(e.last));
    i_ren = 1'b1;
    tick();
    i_ren = 1'b0;
  endtask

  task automatic drain(input string nm);
    while (sb_q.size() > 0) pop_check(nm);
    chk({nm, "_empty_end"}, 32'(o_empty), 32'd1);
  endtask

  initial begin
    i_reset = 1'b1; i_clk_en = 1'b1; i_clr = 1'b0; i_wen = 1'b0; i_weof = 1'b0;
    i_wgood = 1'b0; i_ren = 1'b0; i_wkeep = '0; i_wdata = '0;

    // Post-reset cycle table; head fields compared only when something is committed.
    vt[0]  = mk(0,0,0,0,0, 4'hF, 32'h0,        1, 16'd0, 0, 4'h0, 32'h0);
    vt[1]  = mk(1,0,0,0,0, 4'hF, 32'hA0000001, 1, 16'd0, 0, 4'h0, 32'h0);
    vt[2]  = mk(1,1,1,0,0, 4'h3, 32'hA0000002, 0, 16'd0, 0, 4'hF, 32'hA0000001);
    vt[3]  = mk(0,0,0,1,0, 4'hF, 32'h0,        0, 16'd0, 1, 4'h3, 32'hA0000002);
    vt[4]  = mk(0,0,0,1,0, 4'hF, 32'h0,        1, 16'd0, 0, 4'h0, 32'h0);
    vt[5]  = mk(1,1,0,0,0, 4'hF, 32'hB0000001, 1, 16'd1, 0, 4'h0, 32'h0);
    vt[6]  = mk(1,1,1,0,0, 4'h1, 32'hC0000001, 0, 16'd1, 1, 4'h1, 32'hC0000001);
    vt[7]  = mk(1,0,0,1,0, 4'hF, 32'hD0000001, 1, 16'd1, 0, 4'h0, 32'h0);
    vt[8]  = mk(1,0,0,0,1, 4'hF, 32'hD0000002, 1, 16'd1, 0, 4'h0, 32'h0);
    vt[9]  = mk(1,1,1,0,0, 4'h7, 32'hE0000001, 0, 16'd1, 1, 4'h7, 32'hE0000001);
    vt[10] = mk(0,0,0,1,0, 4'hF, 32'h0,        1, 16'd1, 0, 4'h0, 32'h0);
    vt[11] = mk(0,0,0,1,0, 4'hF, 32'h0,        1, 16'd1, 0, 4'h0, 32'h0);

    tick(); tick();
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_drop", 32'(o_drop_cnt), 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_rkeep_rlast", {27'd0, o_rlast, o_rkeep}, 32'd0);
    i_reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      i_wen = vt[i].wen; i_weof = vt[i].eof; i_wgood = vt[i].good; i_ren = vt[i].ren;
      i_clr = vt[i].clr; i_wkeep = vt[i].keep; i_wdata = vt[i].data;
      tick();
      chk($sformatf("vec%0d_empty", i), 32'(o_empty), 32'(vt[i].e_empty));
      chk($sformatf("vec%0d_ovf", i), 32'(o_overflow), 32'(vt[i].e_ovf));
      chk($sformatf("vec%0d_drop", i), 32'(o_drop_cnt), 32'(vt[i].e_drop));
      if (!vt[i].e_empty) begin
        chk($sformatf("vec%0d_data", i), o_rdata, vt[i].e_data);
        chk($sformatf("vec%0d_keep", i), 32'(o_rkeep), 32'(vt[i].e_keep));
        chk($sformatf("vec%0d_last", i), 32'(o_rlast), 32'(vt[i].e_last));
      end
    end
    i_wen = 1'b0; i_weof = 1'b0; i_wgood = 1'b0; i_ren = 1'b0; i_clr = 1'b0;
    exp_drop = 16'd1;

    // Three-word good frame: invisible until the eof edge, then readable in order.
    for (int i = 0; i < 3; i++) begin
      logic [3:0] k;
      k = (i == 2) ? 4'h3 : 4'hF;
      sb_q.push_back({(i == 2), k, 32'h31000000 + 32'(i)});
      put_word(32'h31000000 + 32'(i), k, (i == 2), 1'b1);
      chk($sformatf("f3_empty_w%0d", i), 32'(o_empty), (i == 2) ? 32'd0 : 32'd1);
    end
    drain("f3");

    // Bad-FCS frame is discarded; following good frame starts cleanly.
    send_frame(4, 1'b0, 32'h41000000, 4'hF);
    exp_drop++;
    chk("bad_empty", 32'(o_empty), 32'd1);
    chk("bad_drop", 32'(o_drop_cnt), 32'(exp_drop));
    send_frame(2, 1'b1, 32'h42000000, 4'h1);
    drain("after_bad");

    // 20-word frame into an empty buffer: overflow on the 17th word only.
    for (int i = 1; i <= 20; i++) begin
      put_word(32'h51000000 + 32'(i), 4'hF, (i == 20), 1'b1);
      chk($sformatf("ovf_w%0d", i), 32'(o_overflow), (i == 17) ? 32'd1 : 32'd0);
    end
    exp_drop++;
    chk("ovf_drop", 32'(o_drop_cnt), 32'(exp_drop));
    chk("ovf_empty", 32'(o_empty), 32'd1);
    send_frame(1, 1'b1, 32'h52000000, 4'h5);
    drain("after_ovf");

    // Exactly-full frame, partial read, then a frame that wraps the storage.
    send_frame(16, 1'b1, 32'h61000000, 4'hF);
    chk("full16_drop", 32'(o_drop_cnt), 32'(exp_drop));
    for (int i = 0; i < 8; i++) pop_check("wrap_a");
    send_frame(8, 1'b1, 32'h62000000, 4'h3);
    chk("wrap_drop", 32'(o_drop_cnt), 32'(exp_drop));
    chk("wrap_sb16", 32'(sb_q.size()), 32'd16);
    drain("wrap_b");

    // Flush with committed words and a frame in flight.
    send_frame(2, 1'b1, 32'h71000000, 4'hF);
    put_word(32'h72000000, 4'hF, 1'b0, 1'b1);
    put_word(32'h72000001, 4'hF, 1'b0, 1'b1);
    i_clr = 1'b1; i_wen = 1'b1; i_ren = 1'b1; i_wdata = 32'h72000002; i_weof = 1'b1;
    i_wgood = 1'b1;
    tick();
    i_clr = 1'b0; i_wen = 1'b0; i_ren = 1'b0; i_weof = 1'b0; i_wgood = 1'b0;
    chk("clr_empty", 32'(o_empty), 32'd1);
    chk("clr_drop", 32'(o_drop_cnt), 32'(exp_drop));
    sb_q.delete();
    send_frame(1, 1'b1, 32'h73000000, 4'h9);
    drain("after_clr");

    // Clock enable low freezes both sides.
    send_frame(2, 1'b1, 32'h81000000, 4'hC);
    i_clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_wen = 1'b1; i_weof = 1'b1; i_wgood = 1'b1; i_ren = 1'b1;
      i_wdata = 32'h82000000 + 32'(i); i_wkeep = 4'hF;
      tick();
      chk($sformatf("cen_empty%0d", i), 32'(o_empty), 32'd0);
      chk($sformatf("cen_data%0d", i), o_rdata, sb_q[0].data);
      chk($sformatf("cen_drop%0d", i), 32'(o_drop_cnt), 32'(exp_drop));
    end
    i_wen = 1'b0; i_weof = 1'b0; i_wgood = 1'b0; i_ren = 1'b0;
    i_clk_en = 1'b1;
    drain("after_cen");

    // Asynchronous reset mid-frame discards everything including the drop count.
    send_frame(1, 1'b1, 32'h91000000, 4'hF);
    put_word(32'h92000000, 4'hF, 1'b0, 1'b1);
    i_wen = 1'b1; i_wdata = 32'h92000001; i_weof = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    chk("arst_empty", 32'(o_empty), 32'd1);
    chk("arst_drop", 32'(o_drop_cnt), 32'd0);
    chk("arst_rdata", o_rdata, 32'd0);
    chk("arst_rkeep_rlast", {27'd0, o_rlast, o_rkeep}, 32'd0);
    i_wen = 1'b0;
    tick();
    i_reset = 1'b0;
    tick();
    sb_q.delete();
    exp_drop = 16'd0;
    send_frame(2, 1'b1, 32'h93000000, 4'h3);
    chk("post_rst_drop", 32'(o_drop_cnt), 32'(exp_drop));
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
